// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit.
// Imported by the pc register and the fetch top.
package fetch_unit_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] PC_STEP = 16'd4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Fetch program counter: hold / step / redirect mux
// plus target alignment check.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            run_i,
  input  logic            load_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            misalign_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            take;
  logic            step;

  assign misalign_o = (target_i[1:0] != 2'b00);

  // load already excludes redirect, so take/step never overlap
  assign take = run_i & redirect_i & ~misalign_o;
  assign step = run_i & load_i;

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      take:    pc_d = target_i;
      step:    pc_d = pc_q + PC_STEP;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc register, IF/ID output
// register with valid/ready handshake, fault FSM.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus4,
  output logic               fault,
  output logic [PC_W-1:0]    fetch_count
);

  state_e             state_q;
  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    opc_q;
  logic [PC_W-1:0]    opc4_q;
  logic               fault_q;
  logic [PC_W-1:0]    cnt_q;

  logic run;
  logic load;
  logic hs;
  logic misalign;

  assign run  = (state_q == RUN);
  assign hs   = valid_q & out_ready;
  assign load = run & (~valid_q | out_ready)
              & ~redirect_valid;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i      (clk),
    .reset_i    (reset),
    .run_i      (run),
    .load_i     (load),
    .redirect_i (redirect_valid),
    .target_i   (redirect_target),
    .pc_o       (pc),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      opc4_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hs && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
          if (redirect_valid) begin
            valid_q <= 1'b0;
            if (misalign) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end else if (load) begin
            valid_q <= 1'b1;
            instr_q <= instr;
            opc_q   <= pc;
            opc4_q  <= pc + PC_STEP;
          end
        end
        FAULT: begin
          // sticky until reset
          state_q <= FAULT;
        end
        default: state_q <= FAULT;
      endcase
    end
  end

  assign out_valid    = valid_q;
  assign out_instr    = instr_q;
  assign out_pc       = opc_q;
  assign out_pc_plus4 = opc4_q;
  assign fault        = fault_q;
  assign fetch_count  = cnt_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, the first fetch address after reset.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have output pc, 16 bits, the fetch address driven to the instruction memory.
REQ-005 The block SHALL have input instr, 32 bits, the memory's combinational read data for pc, same cycle.
REQ-006 The block SHALL have input redirect_valid, 1 bit, a taken branch or jump from downstream.
REQ-007 The block SHALL have input redirect_target, 16 bits, the new fetch address, sampled when redirect_valid=1.
REQ-008 The block SHALL have output out_valid, 1 bit, meaning the IF/ID register holds a valid instruction.
REQ-009 The block SHALL have input out_ready, 1 bit, meaning the decode stage accepts the output this cycle.
REQ-010 The block SHALL have outputs out_instr (32 bits), out_pc (16 bits) and out_pc_plus4 (16 bits), the registered instruction, its address and its address+4.
REQ-011 The block SHALL have output fault, 1 bit, set on a misaligned redirect target.
REQ-012 The block SHALL have output fetch_count, 16 bits, counting accepted handshakes.

Function
REQ-013 The FSM SHALL have two states: RUN and FAULT.
REQ-014 A load SHALL occur in RUN when (!out_valid || out_ready) && !redirect_valid: out_instr<=instr, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
REQ-015 When out_valid=1 and out_ready=0 with no redirect (stall), pc and all out_* registers SHALL hold unchanged.
REQ-016 When out_valid=1, out_ready=1 and no load occurs, out_valid SHALL clear next cycle.
REQ-017 A redirect SHALL take priority over load and stall: out_valid<=0 (flush), and pc<=redirect_target next cycle; the first instruction from the target appears on out_* one cycle later.
REQ-018 If a redirect has redirect_target[1:0]!=0, the FSM SHALL go to FAULT, set fault=1, set out_valid<=0 and freeze pc at its current value.
REQ-019 In FAULT the FSM SHALL ignore all inputs until reset; fault stays 1.
REQ-020 PC arithmetic SHALL be modulo 2^16: 16'hFFFC+4 = 16'h0000, on both pc and out_pc_plus4.
REQ-021 fetch_count SHALL increment when out_valid && out_ready, also in a redirect cycle, saturating at 16'hFFFF.
REQ-022 Fetch-to-output latency SHALL be 1 cycle; throughput SHALL be 1 instruction per cycle when out_ready stays high.

Reset
REQ-023 On reset the block SHALL set: pc=RESET_PC, state=RUN, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, fault=0, fetch_count=0.
REQ-024 Reset SHALL override redirect and handshake inputs in the same cycle, including mid-stall and in FAULT.
REQ-025 The first load after reset SHALL occur in the first cycle with reset low.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef (RUN, FAULT), PC_W=16, INSTR_W=32 and the constant PC_STEP=4.
REQ-027 One sub-module, pc_reg, SHALL contain the pc register, the next-PC mux (hold/+4/target) and the alignment check.

Verification
REQ-028 Streaming: reset, out_ready=1, memory returns 0xFFC4A303@0x00, 0x0064A423@0x04, 0x0062E233@0x08, 0xFE420AE3@0x0C -> these four words appear on out_instr on consecutive cycles with out_pc 0x00..0x0C, and fetch_count=4.
REQ-029 Stall: out_ready=0 for 3 cycles while out_pc=0x04 -> out_pc and out_instr hold 0x04/0x0064A423 and pc holds 0x08; release -> 0x08 appears next cycle.
REQ-030 Redirect: redirect_valid=1, target=0x00 while out_pc=0x0C -> out_valid=0 next cycle; 0xFFC4A303 with out_pc=0x00 appears the cycle after.
REQ-031 Misaligned: redirect target=0x0006 -> fault=1 and out_valid=0 next cycle, pc frozen; assert reset -> fault=0, pc=RESET_PC.
REQ-032 Wrap: RESET_PC=16'hFFFC -> out_pc=0xFFFC with out_pc_plus4=0x0000, and next pc=0x0000.
REQ-033 Reset mid-stall: out_valid=1, out_ready=0, reset=1 -> next cycle out_valid=0, pc=RESET_PC, fetch_count=0.
